// File: rtl/trace_stream_packer.sv
// Buffers trace records in a FIFO and serialises them LSW-first onto a 32-bit valid/ready stream.
// Optional TRACE_PACKER_HDR_EN prefixes each record with a header word {8'hA5, WORDS, drop count}.
module trace_stream_packer #(
  parameter int TRACE_WIDTH    = 128,
  parameter int FIFO_DEPTH     = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        trace_valid_i,
  input  logic [TRACE_WIDTH-1:0]      trace_data_i,
  input  logic                        capture_en_i,
  input  logic                        lock_i,
  output logic                        m_valid_o,
  output logic [31:0]                 m_data_o,
  output logic                        m_last_o,
  input  logic                        m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [DROP_CNT_WIDTH-1:0]   drop_count_o,
  output logic                        done_o
);
  localparam int WORDS = TRACE_WIDTH / 32;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0]             LAST_IDX = IW'(WORDS - 1);
  localparam logic [IW-1:0]             IDX_ONE  = IW'(1);
  localparam logic [AW:0]               PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]               DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
`ifdef TRACE_PACKER_HDR_EN
    , ST_HDR
`endif
  } state_t;

  state_t                    state_q, state_d;
  logic [TRACE_WIDTH-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic                      locked_q, locked_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [TRACE_WIDTH-1:0]    rec_q, rec_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      full, empty, offer, push, pop;
`ifdef TRACE_PACKER_HDR_EN
  logic [31:0]               hdr_q, hdr_d;
`endif

  // Pointers carry a wrap bit, so the difference is the occupancy directly.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DEPTH);
  assign empty = (level == '0);
  assign offer = trace_valid_i && capture_en_i && !locked_q;
  assign push  = offer && !full;

  assign fifo_level_o = rst_n ? level : '0;
  assign drop_count_o = rst_n ? drop_cnt_q : '0;

  always_comb begin
    locked_d   = locked_q | lock_i;
    drop_cnt_d = drop_cnt_q;
    if (offer && full && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + DROP_ONE;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rec_d     = rec_q;
    pop       = 1'b0;
`ifdef TRACE_PACKER_HDR_EN
    hdr_d     = hdr_q;
`endif
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_last_o  = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty)        pop     = 1'b1;
        else if (locked_q) state_d = ST_DONE;
      end
      ST_SEND: begin
        m_valid_o = 1'b1;
        m_data_o  = rec_q[31:0];
        m_last_o  = (idx_q == LAST_IDX);
        if (m_ready_i) begin
          if (!m_last_o) begin
            idx_d = idx_q + IDX_ONE;
            rec_d = rec_q >> 32;
          end
          else if (!empty)   pop     = 1'b1;
          else if (locked_q) state_d = ST_DONE;
          else               state_d = ST_IDLE;
        end
      end
`ifdef TRACE_PACKER_HDR_EN
      ST_HDR: begin
        m_valid_o = 1'b1;
        m_data_o  = hdr_q;
        if (m_ready_i) state_d = ST_SEND;
      end
`endif
      ST_DONE: done_o = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    // A pop from IDLE or from the last SEND word both land here, so back-to-back records have no bubble.
    if (pop) begin
      rec_d = fifo_mem[rd_ptr_q[AW-1:0]];
      idx_d = '0;
`ifdef TRACE_PACKER_HDR_EN
      hdr_d   = {8'hA5, 8'(WORDS), 16'(drop_cnt_q)};
      state_d = ST_HDR;
`else
      state_d = ST_SEND;
`endif
    end
    if (!rst_n) begin
      m_valid_o = 1'b0;
      m_data_o  = '0;
      m_last_o  = 1'b0;
      done_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      locked_q   <= 1'b0;
      drop_cnt_q <= '0;
      rec_q      <= '0;
      idx_q      <= '0;
`ifdef TRACE_PACKER_HDR_EN
      hdr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      locked_q   <= locked_d;
      drop_cnt_q <= drop_cnt_d;
      rec_q      <= rec_d;
      idx_q      <= idx_d;
`ifdef TRACE_PACKER_HDR_EN
      hdr_q      <= hdr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= trace_data_i;
  end

endmodule

// File: doc/trace_stream_packer.md
Name: trace_stream_packer

Overview:
- Output stage directly downstream of the trace unit top.
- Consumes completed trace records plus the capture-enable/lock status, and buffers records in a FIFO.
- Serialises each record into 32-bit words on a valid/ready stream for off-chip transport (UART/DMA bridge).
- Counts records lost to overflow; drains cleanly once the trace unit locks.

Parameters:
- TRACE_WIDTH, 128: packed trace record width in bits; must be a multiple of 32.
- FIFO_DEPTH, 8: record FIFO depth; power of 2, minimum 2.
- DROP_CNT_WIDTH, 16: width of the saturating drop counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- trace_valid_i  input  1  trace_data_i holds a new record this cycle (single-cycle strobe)
- trace_data_i  input  TRACE_WIDTH  packed trace record
- capture_en_i  input  1  trace capture enable from the trace unit
- lock_i  input  1  trace unit lock (repeat detected)
- m_valid_o  output  1  stream word valid
- m_data_o  output  32  stream word
- m_last_o  output  1  final word of the current record
- m_ready_i  input  1  downstream accepts the word
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  records currently buffered
- drop_count_o  output  DROP_CNT_WIDTH  records dropped, saturating
- done_o  output  1  locked and fully drained

Behaviour:
- Reset: clk, rst_n; reset is synchronous, active-low.
  - Reset clears the FIFO, lock latch, drop counter and state (IDLE).
  - All outputs are 0 during reset and in the cycle after reset.
  - Asserting reset mid-record aborts the record with no further words.
- WORDS = TRACE_WIDTH/32.
- Accept: the record is accepted when trace_valid_i && capture_en_i && !locked && !full.
  - full is the registered FIFO state. A pop in the same cycle does not free space for that cycle's push.
- Drop: when trace_valid_i && capture_en_i && !locked && full, the record is discarded.
  - drop_count_o increments by 1 and saturates at all-ones (no wrap).
- Ignored input:
  - trace_valid_i with capture_en_i=0 is ignored and not counted.
  - Any input while locked is ignored.
- Lock latch:
  - The lock latch is set on the first cycle lock_i=1 and stays set until reset.
  - A record presented in that same cycle is still accepted.
- FIFO: circular, with write/read pointers one bit wider than the address (wrap bit distinguishes full from empty).
  - fifo_level_o is updated the cycle after a push/pop.
- Serialiser FSM:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, set word index to 0, go to SEND. Else stay.
  - SEND:
    - m_valid_o=1, m_data_o = record[32*idx +: 32] (least-significant word first).
    - m_last_o=1 when idx==WORDS-1.
    - On m_valid_o && m_ready_i with idx<WORDS-1: idx++.
    - On handshake of the last word:
      - FIFO non-empty: pop the next record and stay in SEND with idx=0. No bubble cycle.
      - Else, locked: go to DONE.
      - Else: go to IDLE.
  - DONE: done_o=1, m_valid_o=0. Terminal until reset.
  - From IDLE, locked with an empty FIFO goes to DONE.
- Stream rules:
  - m_data_o and m_last_o are stable while m_valid_o=1 && !m_ready_i.
  - m_valid_o is never deasserted without a handshake.
- Latency: a record accepted at edge k gives m_valid_o=1 after edge k+1, when the FIFO was empty and the FSM idle.
- Throughput: one word per cycle with m_ready_i held high.

Optional Feature:
- Macro: TRACE_PACKER_HDR_EN.
- Defined:
  - Adds state HDR between the pop and the first SEND word.
  - Header word: [31:24]=8'hA5, [23:16]=WORDS, [15:0] = drop_count_o snapshot (low 16 bits) at pop time.
  - m_last_o=0 on the header word; each record becomes WORDS+1 words.
  - Back-to-back pops enter HDR instead of SEND.
- Undefined: no HDR state; a record is exactly WORDS words.

Test Plan:
- Single record: reset, then one record 128'h4444_4444_3333_3333_2222_2222_1111_1111 with m_ready_i=1.
  - Words 1111_1111, 2222_2222, 3333_3333, 4444_4444 on consecutive cycles.
  - m_last_o only on the 4th word.
  - First m_valid_o at k+1 after acceptance edge k.
- Backpressure: m_ready_i toggles 1,0,0,1,...
  - Words are held stable during stalls; no word is duplicated or skipped; 4 handshakes per record.
- Overflow: m_ready_i=0, 10 back-to-back records with FIFO_DEPTH=8.
  - fifo_level_o=8, drop_count_o=1: the FSM popped record 1 into the shift register before record 9 arrived, so record 9 fits and only record 10 is dropped.
  - Releasing m_ready_i yields records 1-9 in order.
- Capture gating: 3 records with capture_en_i=0, then 1 with capture_en_i=1.
  - Exactly one record is emitted; drop_count_o=0.
- Lock drain: 3 records buffered, lock_i pulsed with a 4th record in the same cycle, then further records offered.
  - 4 records are emitted; later records are ignored.
  - done_o=1 after the final handshake.
  - A subsequent reset clears done_o and the counters.
- Header (TRACE_PACKER_HDR_EN): after 2 drops, the next record starts with word 32'hA504_0002, then 4 data words.
